hyper_mem_model_mc: RTL

HYPER_MEM_MODEL_MC -- requirements
Module: hyper_mem_model_mc

---
 rtl/hyper_mem_model_mc.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/hyper_mem_model_mc.sv
// hyper_mem_model_mc
// Behavioural HyperRAM-style memory model with several independent banks, one per chip select.
// A transaction is a 3-word command/address (CA) phase, an optional latency phase and a data
// burst of one 16-bit word per cycle for as long as the selected chip select stays low.
//
// Ports
//   clk_i      : single clock for all state
//   rst_i      : synchronous, active-high reset (memory contents are preserved)
//   cs_ni      : active-low chip selects, lowest-index low bit picks the bank
//   dq_i       : CA / write data word ([15:8] rising-edge byte, [7:0] falling-edge byte)
//   rwds_i     : write byte masks, 1 = byte masked ([1] -> [15:8], [0] -> [7:0])
//   dq_o       : read data
//   dq_oe_o    : dq drive enable (read data phase)
//   rwds_o     : latency indicator during CA, read strobe during the read data phase
//   rwds_oe_o  : rwds drive enable
//   err_o      : one-cycle protocol error pulse
module hyper_mem_model_mc #(
  parameter int unsigned NUM_CS    = 2,
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [15:0] ID_VALUE  = 16'h0C81
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CS-1:0] cs_ni,
  input  logic [15:0]       dq_i,
  input  logic [1:0]        rwds_i,
  output logic [15:0]       dq_o,
  output logic              dq_oe_o,
  output logic [1:0]        rwds_o,
  output logic              rwds_oe_o,
  output logic              err_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned BW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StCa,
    StLat,
    StWr,
    StRd,
    StRegWr,
    StAbort
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   bank_q;
  logic [47:16]    ca_q;
  logic            ca_last_q;   // next CA word is the final one
  logic            is_rd_q;
  logic            is_reg_q;
  logic            is_lin_q;
  logic [AW-1:0]   addr_q;
  logic [4:0]      lat_q;
  logic [15:0]     cr0_q;

  logic [15:0]     dq_q;
  logic            dq_oe_q;
  logic [1:0]      rwds_q;
  logic            rwds_oe_q;
  logic            err_q;

  logic [15:0]     mem [NUM_CS][MEM_WORDS];

  logic [BW-1:0]   first_bank;
  logic            any_cs;
  logic            multi_cs;
  logic            sel_cs_n;
  logic            cs_live;
  logic [AW-1:0]   ca_addr;
  logic [4:0]      lat_total;
  logic [AW-1:0]   wrap_mask;
  logic [AW-1:0]   nxt_addr;
  logic [AW-1:0]   rd_addr;
  logic            rd_is_reg;
  logic [15:0]     rd_word;
  logic            mem_we;

  // ---------------------------------------------------------------------------------------------
  // Chip-select decode
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    first_bank = '0;
    for (int i = int'(NUM_CS) - 1; i >= 0; i--) begin
      if (!cs_ni[i]) first_bank = BW'(i);
    end
  end

  assign any_cs   = |(~cs_ni);
  assign multi_cs = $countones(~cs_ni) > 1;
  assign sel_cs_n = cs_ni[bank_q];
  // Outputs are only driven while the latched bank is still selected, so a deassert cycle
  // already sees them released.
  assign cs_live  = (state_q != StIdle) && !sel_cs_n;

  // ---------------------------------------------------------------------------------------------
  // Address and latency helpers
  // ---------------------------------------------------------------------------------------------
  // Word address is {CA[44:16], CA[2:0]}; the last CA word is still on dq_i when decoded.
  assign ca_addr   = AW'({ca_q[44:16], dq_i[2:0]});
  assign lat_total = cr0_q[3] ? {cr0_q[7:4], 1'b0} : {1'b0, cr0_q[7:4]};

  always_comb begin
    unique case (cr0_q[1:0])
      2'b00:   wrap_mask = AW'(63);
      2'b01:   wrap_mask = AW'(31);
      2'b10:   wrap_mask = AW'(7);
      default: wrap_mask = AW'(15);
    endcase
  end

  always_comb begin
    if (is_reg_q) begin
      // Register reads repeat the same word, so the address never moves.
      nxt_addr = addr_q;
    end else if (is_lin_q) begin
      nxt_addr = (addr_q == AW'(MEM_WORDS - 1)) ? '0 : addr_q + AW'(1);
    end else begin
      nxt_addr = (addr_q & ~wrap_mask) | ((addr_q + AW'(1)) & wrap_mask);
    end
  end

  // Address of the word that the next read data cycle presents.
  always_comb begin
    unique case (state_q)
      StCa:    rd_addr = ca_addr;
      StRd:    rd_addr = nxt_addr;
      default: rd_addr = addr_q;
    endcase
  end

  assign rd_is_reg = (state_q == StCa) ? ca_q[46] : is_reg_q;

  always_comb begin
    if (rd_is_reg) begin
      rd_word = (rd_addr == '0) ? cr0_q : ID_VALUE;
    end else begin
      rd_word = mem[bank_q][rd_addr];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      bank_q    <= '0;
      ca_q      <= '0;
      ca_last_q <= 1'b0;
      is_rd_q   <= 1'b0;
      is_reg_q  <= 1'b0;
      is_lin_q  <= 1'b0;
      addr_q    <= '0;
      lat_q     <= '0;
      cr0_q     <= 16'h006D;
      dq_q      <= '0;
      dq_oe_q   <= 1'b0;
      rwds_q    <= '0;
      rwds_oe_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dq_q      <= '0;
      dq_oe_q   <= 1'b0;
      rwds_q    <= '0;
      rwds_oe_q <= 1'b0;
      err_q     <= multi_cs;

      unique case (state_q)
        StIdle: begin
          if (any_cs) begin
            bank_q          <= first_bank;
            ca_q[47:32]     <= dq_i;
            ca_last_q       <= 1'b0;
            state_q         <= StCa;
            rwds_oe_q       <= 1'b1;
            rwds_q          <= {2{cr0_q[3]}};
          end
        end

        StCa: begin
          if (sel_cs_n) begin
            // Short CA phase: flag it and drop the transaction.
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else if (!ca_last_q) begin
            ca_q[31:16] <= dq_i;
            ca_last_q   <= 1'b1;
            rwds_oe_q   <= 1'b1;
            rwds_q      <= {2{cr0_q[3]}};
          end else begin
            is_rd_q  <= ca_q[47];
            is_reg_q <= ca_q[46];
            is_lin_q <= ca_q[45];
            addr_q   <= ca_addr;
            if (!ca_q[47] && ca_q[46]) begin
              state_q <= StRegWr;
            end else if (lat_total == '0) begin
              if (ca_q[47]) begin
                state_q   <= StRd;
                dq_q      <= rd_word;
                dq_oe_q   <= 1'b1;
                rwds_oe_q <= 1'b1;
                rwds_q    <= 2'b10;
              end else begin
                state_q <= StWr;
              end
            end else begin
              state_q <= StLat;
              lat_q   <= lat_total;
            end
          end
        end

        StLat: begin
          if (sel_cs_n) begin
            state_q <= StIdle;
          end else if (lat_q == 5'd1) begin
            if (is_rd_q) begin
              state_q   <= StRd;
              dq_q      <= rd_word;
              dq_oe_q   <= 1'b1;
              rwds_oe_q <= 1'b1;
              rwds_q    <= 2'b10;
            end else begin
              state_q <= StWr;
            end
          end else begin
            lat_q <= lat_q - 5'd1;
          end
        end

        StWr: begin
          if (sel_cs_n) begin
            state_q <= StIdle;
          end else begin
            addr_q <= nxt_addr;
          end
        end

        StRd: begin
          if (sel_cs_n) begin
            state_q <= StIdle;
          end else begin
            addr_q    <= nxt_addr;
            dq_q      <= rd_word;
            dq_oe_q   <= 1'b1;
            rwds_oe_q <= 1'b1;
            rwds_q    <= 2'b10;
          end
        end

        StRegWr: begin
          if (sel_cs_n) begin
            state_q <= StIdle;
          end else begin
            if (addr_q == '0) cr0_q <= dq_i;
            // Any further words while cs stays low are ignored.
            state_q <= StAbort;
          end
        end

        StAbort: begin
          if (sel_cs_n) state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Memory array, deliberately not reset
  // ---------------------------------------------------------------------------------------------
  assign mem_we = (state_q == StWr) && !sel_cs_n && !rst_i;

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (!rwds_i[1]) mem[bank_q][addr_q][15:8] <= dq_i[15:8];
      if (!rwds_i[0]) mem[bank_q][addr_q][7:0]  <= dq_i[7:0];
    end
  end

  assign dq_o      = cs_live ? dq_q : '0;
  assign dq_oe_o   = cs_live & dq_oe_q;
  assign rwds_o    = cs_live ? rwds_q : '0;
  assign rwds_oe_o = cs_live & rwds_oe_q;
  assign err_o     = err_q;

endmodule
